// File: rtl/uart_pkg.sv
// Shared types and widths for the uart_tx round-robin scheduler.
package uart_pkg;

  localparam int unsigned TIMEOUT_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } sched_state_t;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Requester and uart_tx side signals of the scheduler.
// UART_TX_SCHED_PKT_LOCK_EN adds req_last and locked.
interface uart_tx_sched_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_send;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [IDW-1:0]       grant_id;
  logic                 active;
  logic                 timeout_err;
`ifdef UART_TX_SCHED_PKT_LOCK_EN
  logic [NUM_REQ-1:0]   req_last;
  logic                 locked;
`endif

  // Scheduler view.
  modport master (
    input  req_valid, req_data, tx_busy,
`ifdef UART_TX_SCHED_PKT_LOCK_EN
    input  req_last,
    output locked,
`endif
    output req_ready, tx_send, tx_data, grant_id, active, timeout_err
  );

  // Requester / transmitter view.
  modport slave (
    output req_valid, req_data, tx_busy,
`ifdef UART_TX_SCHED_PKT_LOCK_EN
    output req_last,
    input  locked,
`endif
    input  req_ready, tx_send, tx_data, grant_id, active, timeout_err
  );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first eligible requester at or after rr_ptr.
module uart_rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] mask,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [IDW-1:0]     win_id,
  output logic [NUM_REQ-1:0] win_oh,
  output logic               win_any
);

  logic [NUM_REQ-1:0] elig;
  int                 idx;

  // Scan from the farthest offset down so the nearest eligible one wins.
  always_comb begin
    elig    = req_valid & mask;
    idx     = 0;
    win_id  = '0;
    win_any = 1'b0;
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      if (elig[IDW'(idx)]) begin
        win_id  = IDW'(idx);
        win_any = 1'b1;
      end
    end
    win_oh = win_any ? (NUM_REQ'(1) << win_id) : '0;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ byte producers.
// Optional packet lock enabled by UART_TX_SCHED_PKT_LOCK_EN.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic            CLK,
  input  logic            RST,
  uart_tx_sched_if.master bus
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  sched_state_t         state, state_n;
  logic [IDW-1:0]       rr_ptr, win_id;
  logic [NUM_REQ-1:0]   win_oh, lock_mask;
  logic                 win_any, xfer, to_hit;
  logic [TIMEOUT_W-1:0] ack_cnt;
  logic [7:0]           win_data;

  function automatic logic [IDW-1:0] ptr_inc(input logic [IDW-1:0] p);
    return (p == IDW'(NUM_REQ - 1)) ? '0 : p + IDW'(1);
  endfunction

`ifdef UART_TX_SCHED_PKT_LOCK_EN
  assign lock_mask = bus.locked ? (NUM_REQ'(1) << bus.grant_id) : '1;
`else
  assign lock_mask = '1;
`endif

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_valid (bus.req_valid),
    .mask      (lock_mask),
    .rr_ptr    (rr_ptr),
    .win_id    (win_id),
    .win_oh    (win_oh),
    .win_any   (win_any)
  );

  always_comb begin
    win_data = 8'h00;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (win_oh[i]) win_data = bus.req_data[8*i +: 8];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (win_any) state_n = SEND;
      SEND:      state_n = WAIT_ACK;
      WAIT_ACK:  if (bus.tx_busy) state_n = WAIT_DONE;
                 else if (to_hit) state_n = IDLE;
      WAIT_DONE: if (!bus.tx_busy) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Handshake strobe and timeout decode; ready is held low during reset.
  always_comb begin
    bus.req_ready = '0;
    xfer          = 1'b0;
    to_hit        = 1'b0;
    if (state == IDLE && !RST) begin
      bus.req_ready = win_oh;
      xfer          = win_any;
    end
    if (state == WAIT_ACK && !bus.tx_busy &&
        ack_cnt == TIMEOUT_W'(ACK_TIMEOUT - 1)) begin
      to_hit = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.tx_send     <= 1'b0;
      bus.tx_data     <= 8'h00;
      bus.grant_id    <= '0;
      bus.active      <= 1'b0;
      bus.timeout_err <= 1'b0;
      rr_ptr          <= '0;
      ack_cnt         <= '0;
`ifdef UART_TX_SCHED_PKT_LOCK_EN
      bus.locked      <= 1'b0;
`endif
    end else begin
      bus.tx_send     <= xfer;
      bus.timeout_err <= to_hit;
      bus.active      <= (state_n != IDLE);
      if (state == SEND)          ack_cnt <= '0;
      else if (state == WAIT_ACK) ack_cnt <= ack_cnt + TIMEOUT_W'(1);
      if (xfer) begin
        bus.tx_data  <= win_data;
        bus.grant_id <= win_id;
`ifdef UART_TX_SCHED_PKT_LOCK_EN
        // Pointer moves only when a packet ends.
        if (bus.req_last[win_id]) begin
          rr_ptr     <= ptr_inc(win_id);
          bus.locked <= 1'b0;
        end else begin
          bus.locked <= 1'b1;
        end
`else
        rr_ptr <= ptr_inc(win_id);
`endif
      end
`ifdef UART_TX_SCHED_PKT_LOCK_EN
      if (to_hit && bus.locked) begin
        bus.locked <= 1'b0;
        rr_ptr     <= ptr_inc(bus.grant_id);
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a simple uart_tx busy model.
module tb_uart_tx_sched;

  localparam int unsigned NR    = 4;
  localparam int unsigned FRAME = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.NUM_REQ(NR)) bus ();

  uart_tx_sched #(.NUM_REQ(NR), .ACK_TIMEOUT(16)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          multi  = 0;
  int          to_pulses = 0;
  int          busy_cnt = 0;
  bit          model_en = 1'b1;
  logic [7:0]  sent_q[$];
  int          gnt_q[$];
  bit          lock_q[$];

  // uart_tx stand-in: busy for FRAME cycles after each Send.
  always @(posedge clk) begin
    if (rst) begin
      busy_cnt    <= 0;
      bus.tx_busy <= 1'b0;
    end else if (bus.tx_send) begin
      sent_q.push_back(bus.tx_data);
      gnt_q.push_back(int'(bus.grant_id));
`ifdef UART_TX_SCHED_PKT_LOCK_EN
      lock_q.push_back(bus.locked);
`endif
      if (model_en) begin
        busy_cnt    <= FRAME;
        bus.tx_busy <= 1'b1;
      end
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else begin
      busy_cnt    <= 0;
      bus.tx_busy <= 1'b0;
    end
    if (bus.timeout_err) to_pulses++;
  end

  // Advance one cycle; requesters drop valid once accepted.
  task automatic step();
    logic [NR-1:0] hs;
    #1;
    hs = bus.req_valid & bus.req_ready;
    if ($countones(hs) > 1) multi++;
    @(negedge clk);
    bus.req_valid = bus.req_valid & ~hs;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", bus.req_ready); end
    checks++; if (bus.tx_send !== 1'b0) begin errors++; $display("FAIL reset_tx_send got %b exp 0", bus.tx_send); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h exp 00", bus.tx_data); end
    checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d exp 0", bus.grant_id); end
    checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL reset_active got %b exp 0", bus.active); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got %b exp 0", bus.timeout_err); end
  endtask

  task automatic test_single();
    rst = 1'b0;
    sent_q.delete(); gnt_q.delete();
    bus.req_data  = 32'h0000_A500;
    bus.req_valid = 4'b0010;
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL single_ready got %b exp 0010", bus.req_ready); end
    step();
    checks++; if (bus.tx_send !== 1'b1) begin errors++; $display("FAIL single_send got %b exp 1", bus.tx_send); end
    checks++; if (bus.tx_data !== 8'hA5) begin errors++; $display("FAIL single_data got %h exp a5", bus.tx_data); end
    checks++; if (bus.grant_id !== 2'd1) begin errors++; $display("FAIL single_grant got %0d exp 1", bus.grant_id); end
    checks++; if (bus.req_ready !== 4'b0) begin errors++; $display("FAIL single_ready_send got %b exp 0000", bus.req_ready); end
    step();
    checks++; if (bus.tx_send !== 1'b0) begin errors++; $display("FAIL single_send_pulse got %b exp 0", bus.tx_send); end
    checks++; if (bus.active !== 1'b1) begin errors++; $display("FAIL single_active got %b exp 1", bus.active); end
    for (int n = 0; n < 60 && bus.active; n++) step();
    checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL single_done got active %b exp 0", bus.active); end
    checks++; if (sent_q.size() != 1 || sent_q[0] !== 8'hA5) begin errors++; $display("FAIL single_serial got %0d bytes first %h exp 1 byte a5", sent_q.size(), sent_q[0]); end
  endtask

  task automatic test_wrap();
    logic [15:0] gg;
    logic [15:0] dd;
    sent_q.delete(); gnt_q.delete();
    bus.req_data  = 32'h3300_0030;
    bus.req_valid = 4'b1001;
    #1;
    // rr_ptr is 2 after the single frame, so requester 3 comes first.
    checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL wrap_first_ready got %b exp 1000", bus.req_ready); end
    for (int n = 0; n < 100 && (bus.active || bus.req_valid != 0); n++) step();
    gg = '0; foreach (gnt_q[i]) gg = {gg[11:0], 4'(gnt_q[i])};
    dd = '0; foreach (sent_q[i]) dd = {dd[7:0], sent_q[i]};
    checks++; if (gnt_q.size() != 2 || gg !== 16'h0030) begin errors++; $display("FAIL wrap_grants got %h (%0d) exp 0030 (2)", gg, gnt_q.size()); end
    checks++; if (dd !== 16'h3330) begin errors++; $display("FAIL wrap_bytes got %h exp 3330", dd); end
    bus.req_valid = 4'b0101;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL wrap_ptr_one got %b exp 0100", bus.req_ready); end
    bus.req_valid = 4'b0000;
    step(); step();
    checks++; if (bus.active !== 1'b0 || bus.tx_send !== 1'b0) begin errors++; $display("FAIL withdraw got active %b send %b exp 0 0", bus.active, bus.tx_send); end
  endtask

  task automatic test_all();
    logic [31:0] dd;
    logic [15:0] gg;
    int gap, max_gap;
    rst = 1'b1; step(); rst = 1'b0;
    sent_q.delete(); gnt_q.delete(); multi = 0;
    bus.req_data  = 32'h1312_1110;
    bus.req_valid = 4'b1111;
    gap = 0; max_gap = 0;
    for (int n = 0; n < 300 && (bus.active || bus.req_valid != 0); n++) begin
      if (!bus.active) gap++; else gap = 0;
      if (gap > max_gap) max_gap = gap;
      step();
    end
    dd = '0; foreach (sent_q[i]) dd = {dd[23:0], sent_q[i]};
    gg = '0; foreach (gnt_q[i]) gg = {gg[11:0], 4'(gnt_q[i])};
    checks++; if (sent_q.size() != 4 || dd !== 32'h1011_1213) begin errors++; $display("FAIL all_bytes got %h (%0d) exp 10111213 (4)", dd, sent_q.size()); end
    checks++; if (gg !== 16'h0123) begin errors++; $display("FAIL all_grants got %h exp 0123", gg); end
    checks++; if (multi != 0) begin errors++; $display("FAIL all_double_grant got %0d exp 0", multi); end
    checks++; if (max_gap > 1) begin errors++; $display("FAIL all_idle_gap got %0d exp <=1", max_gap); end
  endtask

  task automatic test_timeout();
    int n, p0;
    logic [15:0] dd;
    model_en = 1'b0;
    sent_q.delete(); gnt_q.delete();
    p0 = to_pulses;
    bus.req_data  = 32'h0000_4140;
    bus.req_valid = 4'b0011;
    step();
    checks++; if (bus.tx_send !== 1'b1 || bus.grant_id !== 2'd0) begin errors++; $display("FAIL to_send got send %b grant %0d exp 1 0", bus.tx_send, bus.grant_id); end
    n = 0;
    while (n < 40 && !bus.timeout_err) begin step(); n++; end
    // 16 WAIT_ACK cycles, then the registered pulse on the return to IDLE.
    checks++; if (n != 17) begin errors++; $display("FAIL to_latency got %0d exp 17", n); end
    checks++; if (bus.active !== 1'b0) begin errors++; $display("FAIL to_idle got active %b exp 0", bus.active); end
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL to_next_ready got %b exp 0010", bus.req_ready); end
    model_en = 1'b1;
    step();
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL to_pulse_width got %b exp 0", bus.timeout_err); end
    checks++; if (bus.tx_send !== 1'b1 || bus.grant_id !== 2'd1) begin errors++; $display("FAIL to_next_send got send %b grant %0d exp 1 1", bus.tx_send, bus.grant_id); end
    for (int k = 0; k < 60 && (bus.active || bus.req_valid != 0); k++) step();
    dd = '0; foreach (sent_q[i]) dd = {dd[7:0], sent_q[i]};
    checks++; if (dd !== 16'h4041) begin errors++; $display("FAIL to_bytes got %h exp 4041", dd); end
    checks++; if (to_pulses - p0 != 1) begin errors++; $display("FAIL to_pulse_count got %0d exp 1", to_pulses - p0); end
  endtask

  task automatic test_rst_mid();
    int p0;
    p0 = to_pulses;
    bus.req_data  = 32'h0052_0000;
    bus.req_valid = 4'b0100;
    for (int n = 0; n < 20 && !(bus.tx_busy && bus.active); n++) step();
    step(); step();
    checks++; if (bus.tx_busy !== 1'b1 || bus.active !== 1'b1) begin errors++; $display("FAIL rstmid_in_frame got busy %b active %b exp 1 1", bus.tx_busy, bus.active); end
    rst = 1'b1;
    bus.req_data  = 32'h6362_6160;
    bus.req_valid = 4'b1111;
    step();
    checks++; if (bus.tx_send !== 1'b0 || bus.tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_tx got send %b data %h exp 0 00", bus.tx_send, bus.tx_data); end
    checks++; if (bus.grant_id !== 2'd0 || bus.active !== 1'b0) begin errors++; $display("FAIL rstmid_state got grant %0d active %b exp 0 0", bus.grant_id, bus.active); end
    checks++; if (bus.timeout_err !== 1'b0 || bus.req_ready !== 4'b0) begin errors++; $display("FAIL rstmid_strobes got to %b ready %b exp 0 0000", bus.timeout_err, bus.req_ready); end
    rst = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_first_ready got %b exp 0001", bus.req_ready); end
    step();
    checks++; if (bus.grant_id !== 2'd0 || bus.tx_data !== 8'h60) begin errors++; $display("FAIL rstmid_first_grant got %0d %h exp 0 60", bus.grant_id, bus.tx_data); end
    bus.req_valid = 4'b0000;
    for (int n = 0; n < 60 && bus.active; n++) step();
    checks++; if (to_pulses != p0) begin errors++; $display("FAIL rstmid_no_timeout got %0d pulses exp 0", to_pulses - p0); end
  endtask

`ifdef UART_TX_SCHED_PKT_LOCK_EN
  task automatic test_lock();
    int k;
    logic [31:0] dd;
    logic [15:0] gg;
    logic [3:0]  lk;
    rst = 1'b1; step(); rst = 1'b0;
    bus.req_last  = 4'b1111;
    bus.req_data  = 32'h0000_0100;
    bus.req_valid = 4'b0010;
    for (int n = 0; n < 60 && (bus.active || bus.req_valid != 0); n++) step();
    sent_q.delete(); gnt_q.delete(); lock_q.delete();
    bus.req_data  = 32'h00A0_0070;
    bus.req_last  = 4'b1011;
    bus.req_valid = 4'b0101;
    k = 1;
    for (int n = 0; n < 300 && (bus.active || bus.req_valid != 0); n++) begin
      step();
      if (!bus.req_valid[2] && k < 3) begin
        k++;
        bus.req_data[23:16] = 8'hA0 + 8'(k - 1);
        bus.req_last[2]     = (k == 3);
        bus.req_valid[2]    = 1'b1;
      end
    end
    dd = '0; foreach (sent_q[i]) dd = {dd[23:0], sent_q[i]};
    gg = '0; foreach (gnt_q[i]) gg = {gg[11:0], 4'(gnt_q[i])};
    lk = '0; foreach (lock_q[i]) lk = {lk[2:0], lock_q[i]};
    checks++; if (gg !== 16'h2220) begin errors++; $display("FAIL lock_grants got %h exp 2220", gg); end
    checks++; if (dd !== 32'hA0A1_A270) begin errors++; $display("FAIL lock_bytes got %h exp a0a1a270", dd); end
    checks++; if (lk !== 4'b1100) begin errors++; $display("FAIL lock_flag got %b exp 1100", lk); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL lock_release got %b exp 0", bus.locked); end
  endtask
`endif

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
`ifdef UART_TX_SCHED_PKT_LOCK_EN
    bus.req_last  = '1;
`endif
    @(negedge clk);
    test_reset();
    test_single();
    test_wrap();
    test_all();
    test_timeout();
    test_rst_mid();
`ifdef UART_TX_SCHED_PKT_LOCK_EN
    test_lock();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one uart_tx transmitter between NUM_REQ byte producers (debug console, status reporter, command echo, ...).
- Accepts one byte per valid/ready handshake from the winning requester, pulses the transmitter's Send, and tracks its NINTO busy flag through start/data/stop.
- Returns to arbitration only when the frame is done.
- Sits directly in front of uart_tx; shares its CLK and RST.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ACK_TIMEOUT, 16, cycles allowed for tx_busy to rise after tx_send before the byte is abandoned.
- IDW, $clog2(NUM_REQ), width of grant_id (derived localparam, not overridable).

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester byte available; held until accepted.
- req_data  input  8*NUM_REQ  requester i byte in bits [8i+7:8i]; stable while req_valid[i] is high.
- req_ready  output  NUM_REQ  one-hot accept strobe; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- tx_send  output  1  to uart_tx Send; one-cycle pulse.
- tx_data  output  8  to uart_tx Data; registered.
- tx_busy  input  1  from uart_tx NINTO.
- grant_id  output  IDW  index of the requester owning the current frame.
- active  output  1  high whenever state is not IDLE.
- timeout_err  output  1  one-cycle pulse when ACK_TIMEOUT expires.

Behaviour:
- Reset values:
  - state = IDLE.
  - tx_send = 0, tx_data = 8'h00.
  - grant_id = 0, rr_ptr = 0.
  - timeout_err = 0, active = 0, req_ready = 0.
  - Reset mid-frame abandons the byte silently, with no timeout_err pulse. uart_tx is reset by the same RST.
- States:
  - IDLE -> SEND on any req_valid.
  - SEND -> WAIT_ACK unconditionally, one cycle.
  - WAIT_ACK -> WAIT_DONE when tx_busy = 1.
  - WAIT_ACK -> IDLE on timeout.
  - WAIT_DONE -> IDLE when tx_busy = 0.
- Arbitration, IDLE only:
  - Winner is the first i with req_valid[i] = 1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready is combinational: one-hot winner while state = IDLE, zero in every other state.
  - On the transfer edge, capture req_data of the winner into tx_data, load grant_id = winner, and set rr_ptr = winner+1; it wraps NUM_REQ-1 -> 0.
- Latency:
  - Transfer edge at cycle 0 -> tx_send = 1 during cycle 1 (SEND) only.
  - tx_data stays stable from cycle 1 until the next transfer.
- WAIT_ACK:
  - An 8-bit counter cleared on entry increments each cycle.
  - When the counter reaches ACK_TIMEOUT-1 with tx_busy still 0: pulse timeout_err for one cycle, go to IDLE, drop the byte, and keep rr_ptr advanced.
  - If tx_busy rises on that same cycle, the timeout is suppressed and the state goes to WAIT_DONE.
- WAIT_DONE: no timeout; waits indefinitely for tx_busy = 0.
- Back-to-back: a requester holding req_valid high is re-arbitrated in the first IDLE cycle after tx_busy falls. IDLE lasts one cycle when any request is pending.
- Simultaneous requests: all requesters are served in rotation; no requester waits more than NUM_REQ-1 frames.
- req_valid deasserted before acceptance: no transfer, no state change (legal, not an error).

Optional Feature:
- Macro UART_TX_SCHED_PKT_LOCK_EN.
- When defined:
  - Adds input req_last [NUM_REQ].
  - After a transfer from requester g with req_last[g] = 0, the grant is locked: in IDLE, only requester g can win.
  - The lock is released when a byte with req_last = 1 is accepted, or when timeout_err fires.
  - rr_ptr advances only on release.
  - Adds output locked (1 bit, reset 0).
- When undefined: no req_last or locked ports; arbitration happens every byte.

Decomposition:
- Package uart_pkg holds:
  - sched_state_t enum {IDLE, SEND, WAIT_ACK, WAIT_DONE}, 2 bits.
  - Localparam TIMEOUT_W = 8.
- One sub-module, uart_rr_arbiter: combinational winner/one-hot from (req_valid, rr_ptr, lock mask), parameterised by NUM_REQ.
- The FSM, counter and pointer registers stay in uart_tx_sched.

Test Plan:
- Single request: req_valid = 4'b0010 with data 8'hA5 against a real uart_tx model -> req_ready = 4'b0010 for 1 cycle, tx_send pulse next cycle, tx_data = 8'hA5, grant_id = 1, active drops after tx_busy falls, rr_ptr = 2.
- All four requesters valid from reset with data 8'h10/11/12/13 -> serial output 10, 11, 12, 13 in order; no double grants; no idle gap longer than 1 cycle.
- Wrap-around: rr_ptr = 3 with valid = 4'b1001 -> grant 3 then 0; rr_ptr returns to 0 then 1.
- Stuck transmitter: tx_busy tied 0 -> timeout_err pulses exactly 16 cycles after SEND, state returns to IDLE, next requester is served.
- RST asserted in WAIT_DONE -> next cycle all outputs at reset values, no timeout_err; first post-reset grant goes to requester 0.
- With UART_TX_SCHED_PKT_LOCK_EN: requester 2 sends 3 bytes (last on the third) while requester 0 is valid -> 2, 2, 2, then 0; locked high across the packet.
